// File: rtl/alu_req_queue_pkg.sv
// Shared types and constants for the ALU request queue.
// Opcode encodings, the queued request record and the ALU result width.
package alu_pkg;

  localparam logic [1:0] OP_NOT  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  localparam int RES_W = 4;

  typedef struct packed {
    logic [1:0] sel;
    logic [1:0] a;
    logic [1:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu_req_queue_if.sv
// Request and result handshake bundle for alu_req_queue.
// master: requester/consumer side; slave: the queue itself.
interface alu_req_queue_if;
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [1:0]       in_a;
  logic [1:0]       in_b;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_y;
  logic [1:0]       res_sel;

  modport master (
    output in_valid, in_sel, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_y, res_sel
  );

  modport slave (
    input  in_valid, in_sel, in_a, in_b, res_ready,
    output in_ready, res_valid, res_y, res_sel
  );

endinterface

// File: rtl/alu_req_queue_fifo.sv
// Request FIFO for alu_req_queue: storage, wrapping pointers and occupancy.
// The caller gates push with ~full and pop with ~empty.
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  alu_req_t               wdata,
  input  logic                   pop,
  output alu_req_t               head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  alu_req_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH; occupancy only moves when push and pop differ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/alu_req_queue.sv
// alu_req_queue: buffers ALU requests, issues one per cycle to the external
// combinational ALU and registers the result behind a valid/ready handshake.
// Optional per-opcode issue counters: define ALU_REQ_QUEUE_STATS_EN.
module alu_req_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
`ifdef ALU_REQ_QUEUE_STATS_EN
  , parameter int STAT_W = 8
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_req_queue_if.slave         bus,
  output logic [1:0]             alu_sel,
  output logic [1:0]             alu_a,
  output logic [1:0]             alu_b,
  input  logic [RES_W-1:0]       alu_y,
  output logic [$clog2(DEPTH):0] count
`ifdef ALU_REQ_QUEUE_STATS_EN
  , output logic [4*STAT_W-1:0]  stat_cnt
  , input  logic                 stat_clr
`endif
);

  alu_req_t         head;
  alu_req_t         wdata;
  logic             full;
  logic             empty;
  logic             push;
  logic             issue;
  logic             slot_free;
  logic             res_valid_q;
  logic [RES_W-1:0] res_y_q;
  logic [1:0]       res_sel_q;

  assign wdata     = '{sel: bus.in_sel, a: bus.in_a, b: bus.in_b};
  assign bus.in_ready = ~full;
  assign push      = bus.in_valid & ~full;
  assign slot_free = ~res_valid_q | bus.res_ready;
  assign issue     = ~empty & slot_free;

  alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (issue),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // ALU sees the head request; idle inputs are forced to zero when empty.
  always_comb begin
    alu_sel = 2'b00;
    alu_a   = 2'b00;
    alu_b   = 2'b00;
    if (!empty) begin
      alu_sel = head.sel;
      alu_a   = head.a;
      alu_b   = head.b;
    end
  end

  // Result register: captures on issue, drops valid when consumed with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_sel_q   <= 2'b00;
    end else if (issue) begin
      res_valid_q <= 1'b1;
      res_y_q     <= alu_y;
      res_sel_q   <= head.sel;
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_y     = res_y_q;
  assign bus.res_sel   = res_sel_q;

`ifdef ALU_REQ_QUEUE_STATS_EN
  logic [STAT_W-1:0] stat_q [4];

  // Saturating per-opcode issue counters; clear wins over a same-cycle issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) stat_q[k] <= '0;
    end else if (stat_clr) begin
      for (int k = 0; k < 4; k++) stat_q[k] <= '0;
    end else if (issue && (stat_q[head.sel] != '1)) begin
      stat_q[head.sel] <= stat_q[head.sel] + STAT_W'(1);
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_stat
    assign stat_cnt[k*STAT_W +: STAT_W] = stat_q[k];
  end
`endif

endmodule
